// File: rtl/ahb_master_arbiter.sv
// Two-requester (IFU/LSU) AHB-Lite arbiter and burst sequencer.
// Grants one requester at a time and drives single or INCRn line transfers.
module ahb_master_arbiter #(
    parameter int PA_BITS  = 56,
    parameter int AHBW     = 64,
    parameter int LINELEN  = 512,
    parameter int BURST_EN = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               IFUReq,
    input  logic [PA_BITS-1:0] IFUAdr,
    input  logic               IFUBurst,
    output logic               IFUGrant,
    output logic               IFUBeatDone,
    output logic               IFUDone,
    input  logic               LSUReq,
    input  logic [PA_BITS-1:0] LSUAdr,
    input  logic               LSUBurst,
    input  logic               LSUWrite,
    input  logic [2:0]         LSUSize,
    input  logic [AHBW-1:0]    LSUWriteData,
    output logic               LSUGrant,
    output logic               LSUBeatDone,
    output logic               LSUDone,
    output logic [3:0]         BeatCount,
    output logic [PA_BITS-1:0] HADDR,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [1:0]         HTRANS,
    output logic [AHBW-1:0]    HWDATA,
    input  logic               HREADY
);

    // state  | meaning
    // S_IDLE | no owner, arbitrating every cycle
    // S_IFU  | IFU owns the bus until its final data beat
    // S_LSU  | LSU owns the bus until its final data beat

    localparam int         BEATS       = LINELEN / AHBW;
    localparam int         BYTE_SH     = $clog2(AHBW / 8);
    localparam logic [2:0] HSIZE_BUS   = 3'(BYTE_SH);
    localparam logic [4:0] BEATS_C     = 5'(BEATS);
    localparam logic [2:0] HBURST_INCR = (BEATS == 4) ? 3'b011 :
                                         (BEATS == 8) ? 3'b101 : 3'b111;

    if (!(BEATS == 4 || BEATS == 8 || BEATS == 16)) begin : g_bad_linelen
        $error("ahb_master_arbiter: LINELEN/AHBW must be 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE, S_IFU, S_LSU} state_t;

    state_t     state_q, state_d;
    logic [4:0] adr_cnt_q, adr_cnt_d;
    logic [3:0] data_cnt_q, data_cnt_d;
    logic       data_phase_q, data_phase_d;
    logic [1:0] streak_q, streak_d;

    logic               is_ifu, is_lsu, granted;
    logic [PA_BITS-1:0] cur_adr;
    logic               cur_burst;
    logic [4:0]         n_beats;
    logic               addr_active, addr_acc, beat_done, done;

    assign is_ifu    = (state_q == S_IFU);
    assign is_lsu    = (state_q == S_LSU);
    assign granted   = is_ifu | is_lsu;
    assign cur_adr   = is_lsu ? LSUAdr : IFUAdr;
    assign cur_burst = is_lsu ? LSUBurst : (is_ifu & IFUBurst);
    assign n_beats   = cur_burst ? BEATS_C : 5'd1;

    assign addr_active = granted && (adr_cnt_q < n_beats);
    assign addr_acc    = addr_active & HREADY;
    assign beat_done   = data_phase_q & HREADY;
    assign done        = beat_done && ({1'b0, data_cnt_q} == (n_beats - 5'd1));

    // All bus outputs decode from registered state and counters only.
    assign HTRANS = !addr_active ? 2'b00 :
                    ((adr_cnt_q == 5'd0) || (BURST_EN == 0)) ? 2'b10 : 2'b11;
    assign HADDR  = granted ? (cur_adr + (PA_BITS'(adr_cnt_q) << BYTE_SH)) : '0;
    assign HBURST = (granted && cur_burst && (BURST_EN != 0)) ? HBURST_INCR : 3'b000;
    assign HSIZE  = !granted ? 3'b000 : (is_lsu && !LSUBurst) ? LSUSize : HSIZE_BUS;
    assign HWRITE = is_lsu & LSUWrite;
    assign HWDATA = LSUWriteData;

    assign IFUGrant    = is_ifu;
    assign LSUGrant    = is_lsu;
    assign IFUBeatDone = is_ifu & beat_done;
    assign LSUBeatDone = is_lsu & beat_done;
    assign IFUDone     = is_ifu & done;
    assign LSUDone     = is_lsu & done;
    assign BeatCount   = data_cnt_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            adr_cnt_q    <= '0;
            data_cnt_q   <= '0;
            data_phase_q <= 1'b0;
            streak_q     <= '0;
        end else begin
            state_q      <= state_d;
            adr_cnt_q    <= adr_cnt_d;
            data_cnt_q   <= data_cnt_d;
            data_phase_q <= data_phase_d;
            streak_q     <= streak_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        adr_cnt_d    = adr_cnt_q;
        data_cnt_d   = data_cnt_q;
        streak_d     = streak_q;
        data_phase_d = addr_acc | (data_phase_q & ~HREADY);
        if (addr_acc)
            adr_cnt_d = adr_cnt_q + 5'd1;
        if (beat_done)
            data_cnt_d = data_cnt_q + 4'd1;

        // Re-arbitrate on the completing beat so back-to-back grants lose no cycle.
        if (state_q == S_IDLE || done) begin
            state_d      = S_IDLE;
            adr_cnt_d    = '0;
            data_cnt_d   = '0;
            data_phase_d = 1'b0;
            if (LSUReq && !(streak_q == 2'd2 && IFUReq)) begin
                state_d = S_LSU;
                if (IFUReq && streak_q != 2'd2)
                    streak_d = streak_q + 2'd1;
            end else if (IFUReq) begin
                state_d  = S_IFU;
                streak_d = '0;
            end
        end
    end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-requester AHB-Lite bus arbiter and burst sequencer between the IFU (instruction fetch) and the LSU (load/store unit). It sits in front of the single external AHB master port. It grants the bus to one requester at a time and generates HTRANS/HADDR/HBURST for single transfers or full cache-line bursts. It also counts address and data beats and signals per-beat and end-of-transaction completion to the granted requester.

## Interface
Parameters:
- PA_BITS, 56, physical address width.
- AHBW, 64, AHB data width in bits.
- LINELEN, 512, cache line length in bits. BEATS = LINELEN/AHBW must be 4, 8 or 16; any other value is an elaboration error.
- BURST_EN, 1, 1 = issue line fills as INCRn bursts; 0 = issue BEATS single transfers.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, synchronous, active-low
- IFUReq  in  1  IFU read request; held until IFUDone
- IFUAdr  in  PA_BITS  IFU base address
- IFUBurst  in  1  1 = line read, 0 = single read
- IFUGrant  out  1  IFU owns the bus
- IFUBeatDone  out  1  IFU data beat completed this cycle
- IFUDone  out  1  final IFU data beat completed this cycle
- LSUReq, LSUAdr, LSUBurst  in  1/PA_BITS/1  same as IFU
- LSUWrite  in  1  1 = write
- LSUSize  in  3  HSIZE for single transfers
- LSUWriteData  in  AHBW  write data for current data beat
- LSUGrant, LSUBeatDone, LSUDone  out  1  same as IFU
- BeatCount  out  4  index of current data-phase beat
- HADDR  out  PA_BITS; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HTRANS  out  2; HWDATA  out  AHBW
- HREADY  in  1  AHB ready

## Operation
- States:
  - IDLE.
  - IFU: IFU transaction active.
  - LSU: LSU transaction active.
- Arbitration (in IDLE, or at a completing final beat):
  - LSU has priority.
  - Exception: if the LSU streak counter is 2 and IFUReq is high, IFU wins.
  - The streak counter increments on each LSU grant while IFUReq is high, clears on any IFU grant, and saturates at 2.
- No preemption. A grant holds until the final data beat completes.
- Transaction length N:
  - N = BEATS if Burst = 1.
  - N = 1 otherwise.
- Counters:
  - AdrCnt (0..N) counts address phases accepted (HTRANS != IDLE and HREADY).
  - DataCnt counts data phases completed.
  - DataPhase flag is registered: set when an address phase is accepted, cleared when a data phase completes without a new address being accepted.
- Address beat i drives:
  - HADDR = Adr + i·(AHBW/8).
  - Burst base must be aligned to LINELEN/8; misalignment is undefined.
- HTRANS:
  - NONSEQ (10) for beat 0.
  - SEQ (11) for later beats when BURST_EN=1.
  - NONSEQ for every beat when BURST_EN=0.
  - IDLE (00) once AdrCnt = N, or when no grant.
- HBURST:
  - INCR4 = 011, INCR8 = 101, INCR16 = 111 for BEATS = 4/8/16 when Burst=1 and BURST_EN=1.
  - SINGLE (000) otherwise.
- HSIZE:
  - log2(AHBW/8) for bursts and for IFU singles.
  - LSUSize for LSU singles.
- HWRITE: LSUWrite while LSU is granted, else 0.
- HWDATA = LSUWriteData. BeatCount = DataCnt.
- BeatDone pulses on DataPhase & HREADY. Done pulses when that beat is number N−1.
- A request must be held with stable Adr/Burst/Write/Size until Done; violation is undefined.

## Timing
- Reset (HRESETn low at an edge): next cycle state=IDLE and all counters/flags clear. Outputs are then:
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0.
  - Grants and done signals 0. Streak counter 0.
- Reset mid-transaction abandons it: no Done is issued.
- Request latency:
  - Req sampled high in IDLE at edge k.
  - Grant and NONSEQ beat 0 are driven in cycle k+1.
  - All AHB outputs are decoded from registered state and counters.
- HREADY low holds HADDR/HTRANS/HBURST and both counters unchanged.
- With zero wait states, a transaction of N beats takes N+1 cycles from grant to Done inclusive. The final data cycle drives HTRANS=00.
- At Done:
  - If a request is pending, the next grant's NONSEQ appears in the following cycle; no extra idle cycle.
  - Otherwise the block returns to IDLE.
- Simultaneous IFUReq/LSUReq: resolved per arbitration rule in the same cycle.

## Test plan
- LSU single write, Adr=0x80000010, Size=011, HREADY=1:
  - Cycle 1: HTRANS=10, HADDR=0x80000010, HWRITE=1, HBURST=000.
  - Cycle 2: HTRANS=00, LSUDone=1.
- IFU burst (AHBW=64, LINELEN=512), Adr=0x1000:
  - HBURST=101; HTRANS 10 then 11 ×7; HADDR 0x1000…0x1038.
  - 8 IFUBeatDone pulses; IFUDone in cycle 9.
- Same burst with HREADY low 2 cycles during beat 3:
  - HADDR held at 0x1020; BeatCount held.
  - IFUDone in cycle 11.
- IFU and LSU both requesting continuously:
  - Grant order LSU, LSU, IFU, LSU, LSU, IFU.
  - Zero idle cycles between transactions.
- BURST_EN=0, IFU line read: 8 NONSEQ transfers, HBURST=000, addresses +8 each.
- HRESETn low during beat 4 of an IFU burst:
  - Next cycle HTRANS=00, IFUGrant=0, no IFUDone.
  - After release with IFUReq high: NONSEQ at base address, BeatCount=0.
